uart_parity_engine: RTL and testbench

UART_PARITY_ENGINE -- requirements
Module: uart_parity_engine

---
 rtl/uart_parity_engine.sv | 174 +++++++++++++++++
 tb/tb_uart_parity_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// UART parity engine: registered TX parity generator plus a bit-serial RX
// parity checker. Both paths share the configuration inputs but run
// independently and may be active in the same cycle.
//
// Strobe semantics: tx_load, rx_start, rx_bit_valid and rx_par_valid are
// single-cycle qualifiers sampled on the rising clk edge. There is no ready
// or back-pressure. A strobe is consumed in the cycle it is high or ignored
// when the RX FSM is not in the state that uses it. rx_start always wins over
// a coinciding data or parity strobe.
module uart_parity_engine #(
  parameter int MAX_WIDTH = 8,
  localparam int LW = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cfg_par_type,
  input  logic                 cfg_par_en,
  input  logic [LW-1:0]        cfg_data_len,
  input  logic                 tx_load,
  input  logic [MAX_WIDTH-1:0] tx_data,
  output logic                 tx_parity,
  input  logic                 rx_start,
  input  logic                 rx_bit_valid,
  input  logic                 rx_bit,
  input  logic                 rx_par_valid,
  input  logic                 rx_par_bit,
  output logic                 rx_busy,
  output logic                 par_err_valid,
  output logic                 par_err,
  output logic [1:0]           rx_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WAIT_PAR = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] eff_len;
  logic          tx_xor;
  logic          rx_acc;
  logic [LW-1:0] bit_cnt;
  logic [LW-1:0] lat_len;
  logic [1:0]    lat_type;
  logic          lat_en;
  logic          last_bit;

  // Map a raw XOR of the data bits onto the selected parity mode.
  function automatic logic apply_type(input logic x, input logic [1:0] ptype);
    logic r;
    case (ptype)
      2'b00:   r = x;
      2'b01:   r = ~x;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Clamp the configured frame length into the supported range.
  always_comb begin
    eff_len = cfg_data_len;
    if (cfg_data_len < LW'(5)) begin
      eff_len = LW'(5);
    end else if (cfg_data_len > LW'(MAX_WIDTH)) begin
      eff_len = LW'(MAX_WIDTH);
    end
  end

  // XOR of the TX data bits below the effective length; upper bits are masked.
  always_comb begin
    tx_xor = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < int'(eff_len)) begin
        tx_xor = tx_xor ^ tx_data[i];
      end
    end
  end

  // TX parity register: only a load changes it, config changes alone do not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_parity <= 1'b0;
    end else if (tx_load) begin
      tx_parity <= apply_type(tx_xor, cfg_par_type);
    end
  end

  // The data bit being accepted this cycle completes the frame.
  assign last_bit = ((bit_cnt + LW'(1)) == lat_len);

  // RX FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // RX FSM next-state logic; rx_start restarts from any state.
  always_comb begin
    state_next = state;
    if (rx_start) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (rx_bit_valid && last_bit) begin
            state_next = lat_en ? WAIT_PAR : IDLE;
          end
        end
        WAIT_PAR: begin
          if (rx_par_valid) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // RX FSM outputs decoded from the current state.
  always_comb begin
    rx_busy  = (state != IDLE);
    rx_state = state;
  end

  // RX datapath: accumulator, bit counter, latched frame config and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_acc        <= 1'b0;
      bit_cnt       <= '0;
      lat_len       <= '0;
      lat_type      <= 2'b00;
      lat_en        <= 1'b0;
      par_err       <= 1'b0;
      par_err_valid <= 1'b0;
    end else begin
      par_err_valid <= 1'b0;
      if (rx_start) begin
        rx_acc   <= 1'b0;
        bit_cnt  <= '0;
        lat_len  <= eff_len;
        lat_type <= cfg_par_type;
        lat_en   <= cfg_par_en;
        par_err  <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (rx_bit_valid) begin
              rx_acc  <= rx_acc ^ rx_bit;
              bit_cnt <= bit_cnt + LW'(1);
              if (last_bit && !lat_en) begin
                par_err_valid <= 1'b1;
                par_err       <= 1'b0;
              end
            end
          end
          WAIT_PAR: begin
            if (rx_par_valid) begin
              par_err_valid <= 1'b1;
              par_err       <= (rx_par_bit != apply_type(rx_acc, lat_type));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed frames plus random
// TX loads and RX frames, compared against a frame-level parity model.
module tb_uart_parity_engine;

  localparam int MW = 8;
  localparam int LW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cfg_par_type = 2'b00;
  logic          cfg_par_en = 1'b0;
  logic [LW-1:0] cfg_data_len = '0;
  logic          tx_load = 1'b0;
  logic [MW-1:0] tx_data = '0;
  logic          tx_parity;
  logic          rx_start = 1'b0;
  logic          rx_bit_valid = 1'b0;
  logic          rx_bit = 1'b0;
  logic          rx_par_valid = 1'b0;
  logic          rx_par_bit = 1'b0;
  logic          rx_busy;
  logic          par_err_valid;
  logic          par_err;
  logic [1:0]    rx_state;

  int n_tests = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  uart_parity_engine #(.MAX_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .cfg_par_type(cfg_par_type), .cfg_par_en(cfg_par_en), .cfg_data_len(cfg_data_len),
    .tx_load(tx_load), .tx_data(tx_data), .tx_parity(tx_parity),
    .rx_start(rx_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
    .rx_par_valid(rx_par_valid), .rx_par_bit(rx_par_bit),
    .rx_busy(rx_busy), .par_err_valid(par_err_valid), .par_err(par_err),
    .rx_state(rx_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Count result pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (par_err_valid === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  function automatic int eff_len(input int len);
    if (len < 5) return 5;
    if (len > MW) return MW;
    return len;
  endfunction

  function automatic logic ref_par(input int data, input int len, input int ptype);
    int ones;
    ones = $countones(data & ((1 << eff_len(len)) - 1));
    case (ptype)
      0: return logic'(ones % 2);
      1: return logic'(1 - (ones % 2));
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Load TX data, check the parity, then check it holds across config changes.
  task automatic tx_case(input string tag, input int data, input int len, input int ptype);
    logic exp;
    exp = ref_par(data, len, ptype);
    cfg_data_len = LW'(len);
    cfg_par_type = 2'(ptype);
    tx_data = MW'(data);
    tx_load = 1'b1;
    step();
    tx_load = 1'b0;
    check(tag, tx_parity, exp);
    cfg_par_type = 2'($urandom_range(0, 3));
    cfg_data_len = LW'($urandom_range(0, 15));
    tx_data = MW'($urandom);
    step();
    check({tag, "_hold"}, tx_parity, exp);
  endtask

  // Drive one RX frame with random gaps and stray strobes, checking the result.
  task automatic rx_frame(input string tag, input int data, input int len, input int ptype,
                          input bit en, input bit par_bit, input bit bit_on_start,
                          input int max_gap, input int pulse_base);
    int   n;
    logic exp_err;
    logic tx_exp;
    n = eff_len(len);
    exp_err = en ? (par_bit != ref_par(data, len, ptype)) : 1'b0;
    cfg_data_len = LW'(len);
    cfg_par_type = 2'(ptype);
    cfg_par_en = en;
    rx_start = 1'b1;
    rx_bit_valid = bit_on_start;
    rx_bit = 1'($urandom);
    rx_par_valid = 1'($urandom);
    step();
    rx_start = 1'b0;
    rx_bit_valid = 1'b0;
    rx_par_valid = 1'b0;
    check({tag, "_busy_start"}, rx_busy, 1);
    check({tag, "_err_clr"}, par_err, 0);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
        rx_par_valid = 1'($urandom);
        rx_bit = 1'($urandom);
        step();
      end
      rx_par_valid = 1'b0;
      rx_bit_valid = 1'b1;
      rx_bit = 1'((data >> i) & 1);
      if (i == 0) begin
        // Scramble config and load TX in the same cycle as an RX bit.
        cfg_par_type = 2'($urandom_range(0, 3));
        cfg_data_len = LW'($urandom_range(0, 15));
        cfg_par_en = 1'($urandom);
        tx_data = MW'($urandom);
        tx_exp = ref_par(int'(tx_data), int'(cfg_data_len), int'(cfg_par_type));
        tx_load = 1'b1;
      end
      step();
      rx_bit_valid = 1'b0;
      if (i == 0) begin
        tx_load = 1'b0;
        check({tag, "_tx_same_cycle"}, tx_parity, tx_exp);
      end
    end
    if (!en) begin
      check({tag, "_pv"}, par_err_valid, 1);
      check({tag, "_err"}, par_err, 0);
      check({tag, "_busy_end"}, rx_busy, 0);
    end else begin
      check({tag, "_busy_wait"}, rx_busy, 1);
      check({tag, "_pv_early"}, par_err_valid, 0);
      for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
        rx_bit_valid = 1'b1;
        rx_bit = 1'($urandom);
        step();
      end
      rx_bit_valid = 1'b0;
      rx_par_valid = 1'b1;
      rx_par_bit = par_bit;
      step();
      rx_par_valid = 1'b0;
      check({tag, "_pv"}, par_err_valid, 1);
      check({tag, "_err"}, par_err, exp_err);
      check({tag, "_busy_end"}, rx_busy, 0);
    end
    step();
    check({tag, "_pv_one_cycle"}, par_err_valid, 0);
    check({tag, "_err_hold"}, par_err, exp_err);
    check({tag, "_pulses"}, pulse_cnt - pulse_base, 1);
  endtask

  initial begin
    int pb;
    // Reset
    step();
    step();
    check("rst_tx_parity", tx_parity, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_pv", par_err_valid, 0);
    check("rst_err", par_err, 0);
    check("rst_state", rx_state, 0);
    rst = 1'b1;
    step();

    // TX directed: 0x53 has four ones in the low eight bits.
    tx_case("tx_even_53", 'h53, 8, 0);
    check("tx_even_53_val", tx_parity, 0);
    tx_case("tx_odd_53", 'h53, 8, 1);
    tx_case("tx_mark_53", 'h53, 8, 2);
    tx_case("tx_space_53", 'h53, 8, 3);
    // 0xE3 at L=5: only bits 4:0 (00011) count, giving even parity 0.
    tx_case("tx_l5_e3", 'hE3, 5, 0);
    tx_case("tx_l3_e3", 'hE3, 3, 0);
    tx_case("tx_l15_clamp", 'hFE, 15, 0);

    // RX directed: 0x53, even, L=8, correct then wrong parity bit.
    rx_frame("rx_53_ok", 'h53, 8, 0, 1'b1, 1'b0, 1'b0, 0, pulse_cnt);
    rx_frame("rx_53_bad", 'h53, 8, 0, 1'b1, 1'b1, 1'b0, 2, pulse_cnt);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rx_53_bad_held", par_err, 1);
    end

    // RX without parity, L=7, then a stray parity strobe.
    rx_frame("rx_nopar_l7", 'h35, 7, 0, 1'b0, 1'b0, 1'b0, 1, pulse_cnt);
    pb = pulse_cnt;
    rx_par_valid = 1'b1;
    rx_par_bit = 1'b1;
    step();
    rx_par_valid = 1'b0;
    check("stray_par_pv", par_err_valid, 0);
    check("stray_par_busy", rx_busy, 0);
    check("stray_par_err", par_err, 0);
    step();
    check("stray_par_pulses", pulse_cnt - pb, 0);

    // Abort: four bits, then a restart coinciding with a data bit.
    pb = pulse_cnt;
    cfg_data_len = LW'(8);
    cfg_par_type = 2'b00;
    cfg_par_en = 1'b1;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit = 1'b1;
      step();
    end
    rx_bit_valid = 1'b0;
    rx_frame("rx_abort", 'hA7, 8, 1, 1'b1, 1'b1, 1'b1, 1, pb);

    // Reset while waiting for the parity bit.
    tx_case("tx_pre_rst", 'h01, 8, 0);
    cfg_data_len = LW'(5);
    cfg_par_en = 1'b1;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_bit_valid = 1'b1;
      rx_bit = 1'($urandom);
      step();
    end
    rx_bit_valid = 1'b0;
    check("pre_rst_busy", rx_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", rx_busy, 0);
    check("async_rst_err", par_err, 0);
    check("async_rst_tx", tx_parity, 0);
    check("async_rst_pv", par_err_valid, 0);
    check("async_rst_state", rx_state, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rx_frame("rx_post_rst", 'h5C, 6, 1, 1'b1, 1'b0, 1'b0, 1, pulse_cnt);
    tx_case("tx_post_rst", 'h5C, 6, 1);

    // Random TX loads and RX frames.
    for (int k = 0; k < 30; k++) begin
      tx_case("tx_rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 25; k++) begin
      rx_frame("rx_rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
               2, pulse_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
